// File: rtl/bus_pkg.sv
// Shared definitions for the M65C02 CPU-side bus bridge.
//   IO_* : core IO_Op encodings
//   MC_ACCESS : microcycle in which the bus access is performed
//   bus_state_t / ST_* : bridge FSM state encoding
//   idx_w() : index width that stays legal for a single slave
package bus_pkg;

  localparam logic [1:0] IO_NONE  = 2'b00;
  localparam logic [1:0] IO_WRITE = 2'b01;
  localparam logic [1:0] IO_READ  = 2'b10;
  localparam logic [1:0] IO_FETCH = 2'b11;

  localparam logic [2:0] MC_ACCESS = 3'b111;

  typedef logic [0:0] bus_state_t;
  localparam bus_state_t ST_IDLE = 1'b0;
  localparam bus_state_t ST_WAIT = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_prio_sel.sv
// Lowest-index priority encoder with read-data mux.
//   sel_i   : candidate select vector
//   rdata_i : packed slave read data, slave i at [8i+7:8i]
//   idx_o   : index of the lowest asserted select bit
//   vld_o   : at least one select bit is asserted
//   rdata_o : read data of the winning slave (0 when none)
module bus_prio_sel
  import bus_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]   sel_i,
  input  logic [8*N-1:0] rdata_i,
  output logic [IW-1:0]  idx_o,
  output logic           vld_o,
  output logic [7:0]     rdata_o
);

  // Scan from the top down so the lowest asserted index is the last write.
  always_comb begin
    idx_o   = '0;
    vld_o   = 1'b0;
    rdata_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_i[i]) begin
        idx_o   = IW'(i);
        vld_o   = 1'b1;
        rdata_o = rdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/m65c02_bus_bridge.sv
// Bus bridge between the M65C02 core and NUM_SLAVES memory/peripheral slaves.
// Decodes IO_Op/MC into one-cycle slave strobes, stretches the core with
// cpu_wait until the selected slave is ready, and registers read data.
// Optional macro BUS_TIMEOUT_EN adds a WAIT timeout watchdog and err_timeout.
//   clk, rst_n           : clock, async active-low reset
//   cpu_addr/_data_out   : core address / write data
//   cpu_io_op, cpu_mc    : core IO_Op and microcycle
//   cpu_data_in          : registered read data to core
//   cpu_wait             : stall request to core
//   slv_sel/_ready/_rdata: per-slave select, ready, read data
//   slv_we/_re/_wdata    : one-hot write/read strobes, write data
//   err_*                : sticky error flags, first-error address, clear
module m65c02_bus_bridge
  import bus_pkg::*;
#(
  parameter int         NUM_SLAVES     = 8,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] DEFAULT_RDATA  = 8'hFF,
  parameter logic [7:0] RESET_RDATA    = 8'hEA
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             cpu_addr,
  input  logic [7:0]              cpu_data_out,
  input  logic [1:0]              cpu_io_op,
  input  logic [2:0]              cpu_mc,
  output logic [7:0]              cpu_data_in,
  output logic                    cpu_wait,
  input  logic [NUM_SLAVES-1:0]   slv_sel,
  output logic [NUM_SLAVES-1:0]   slv_we,
  output logic [NUM_SLAVES-1:0]   slv_re,
  output logic [7:0]              slv_wdata,
  input  logic [8*NUM_SLAVES-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]   slv_ready,
  output logic                    err_timeout,
  output logic                    err_unmapped,
  output logic [15:0]             err_addr,
  input  logic                    err_clr
);

  localparam int IW = idx_w(NUM_SLAVES);

  bus_state_t            state_q, state_d;
  logic [NUM_SLAVES-1:0] win_mask_q;
  logic [15:0]           addr_q;
  logic                  rd_q;
  logic [7:0]            data_q;
  logic                  err_unm_q;
  logic [15:0]           err_addr_q;

  logic [NUM_SLAVES-1:0] sel_eff, win_oh;
  logic [IW-1:0]         win_idx;
  logic                  win_vld, win_rdy, access, rd_now, timeout_w;
  logic [7:0]            win_rdata, ld_val;
  logic                  ld_data, set_unm, set_to;
  logic [15:0]           err_a;

  // In WAIT the latched winner replaces the live selects, so a decoder that
  // changes its mind mid-access cannot redirect completion or read data.
  assign sel_eff = (state_q == ST_WAIT) ? win_mask_q : slv_sel;

  bus_prio_sel #(.N(NUM_SLAVES), .IW(IW)) u_prio (
    .sel_i   (sel_eff),
    .rdata_i (slv_rdata),
    .idx_o   (win_idx),
    .vld_o   (win_vld),
    .rdata_o (win_rdata)
  );

  // rst_n gates the combinational outputs so reset silences them at once.
  assign access  = rst_n && (state_q == ST_IDLE) && (cpu_mc == MC_ACCESS) &&
                   (cpu_io_op != IO_NONE);
  assign rd_now  = cpu_io_op[1];  // read and fetch
  assign win_oh  = NUM_SLAVES'(1) << win_idx;
  assign win_rdy = win_vld && slv_ready[win_idx];

  assign slv_we    = (access && win_vld && cpu_io_op == IO_WRITE) ? win_oh : '0;
  assign slv_re    = (access && win_vld && rd_now) ? win_oh : '0;
  assign slv_wdata = cpu_data_out;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_to_q;

  // cnt_q counts WAIT cycles already spent, so the TIMEOUT_CYCLES-th
  // WAIT cycle is the forced-completion cycle.
  assign timeout_w = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (access)             cnt_q <= '0;
    else if (state_q == ST_WAIT) cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_to_q <= 1'b0;
    else if (err_clr) err_to_q <= 1'b0;
    else if (set_to)  err_to_q <= 1'b1;
  end

  assign err_timeout = err_to_q;
`else
  assign timeout_w   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cpu_wait = 1'b0;
    ld_data  = 1'b0;
    ld_val   = win_rdata;
    set_unm  = 1'b0;
    set_to   = 1'b0;
    err_a    = cpu_addr;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (!win_vld) begin
            set_unm = 1'b1;
            ld_data = rd_now;
            ld_val  = DEFAULT_RDATA;
          end else if (win_rdy) begin
            ld_data = rd_now;
          end else begin
            cpu_wait = 1'b1;
            state_d  = ST_WAIT;
          end
        end
      end
      default: begin
        err_a = addr_q;
        // Ready takes precedence over a coinciding timeout.
        if (win_rdy) begin
          ld_data = rd_q;
          state_d = ST_IDLE;
        end else if (timeout_w) begin
          ld_data = rd_q;
          ld_val  = DEFAULT_RDATA;
          set_to  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cpu_wait = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_mask_q <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      data_q     <= RESET_RDATA;
    end else begin
      state_q <= state_d;
      if (access) begin
        win_mask_q <= win_oh;
        addr_q     <= cpu_addr;
        rd_q       <= rd_now;
      end
      if (ld_data) data_q <= ld_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unm_q  <= 1'b0;
      err_addr_q <= '0;
    end else if (err_clr) begin
      err_unm_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (set_unm) err_unm_q <= 1'b1;
      // Only the first error since the last clear records its address.
      if ((set_unm || set_to) && !(err_unm_q || err_timeout)) err_addr_q <= err_a;
    end
  end

  assign cpu_data_in  = data_q;
  assign err_unmapped = err_unm_q;
  assign err_addr     = err_addr_q;

endmodule

// File: doc/m65c02_bus_bridge.md
# m65c02_bus_bridge

Parametrised CPU-side bus bridge between the M65C02 core and N memory/peripheral slaves. Decodes the core's IO_Op/MC microcycle signals into single-cycle slave read/write strobes and routes read data through a registered, prioritised multiplexer. Adds per-slave ready handshaking, driving the core's Wait input so slow peripherals (LCD, future PS/2, SD) can stretch an access. Includes an optional timeout watchdog with error capture. Sits between the address decoder outputs and `M65C02_Core` in `soc_top`.

## Interface
- `NUM_SLAVES`, 8: number of slave ports; minimum 1, maximum 16.
- `TIMEOUT_CYCLES`, 64: maximum clk cycles in WAIT before forced completion; minimum 2.
- `DEFAULT_RDATA`, 8'hFF: read data returned for unmapped or timed-out reads.
- `RESET_RDATA`, 8'hEA: `cpu_data_in` value while in reset (NOP).

Ports:
- `clk` in 1: system clock, 25 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `cpu_addr` in 16: core AO.
- `cpu_data_out` in 8: core DO.
- `cpu_io_op` in 2: core IO_Op; 00 none, 01 write, 10 read, 11 fetch.
- `cpu_mc` in 3: core MC.
- `cpu_data_in` out 8: registered read data to core DI.
- `cpu_wait` out 1: to core Wait.
- `slv_sel` in NUM_SLAVES: chip selects from the address decoder.
- `slv_we` out NUM_SLAVES: one-hot write strobe.
- `slv_re` out NUM_SLAVES: one-hot read strobe; fetch counts as read.
- `slv_wdata` out 8: equals `cpu_data_out`.
- `slv_rdata` in 8*NUM_SLAVES: slave i occupies bits [8i+7:8i].
- `slv_ready` in NUM_SLAVES: slave i completes the access in any cycle where this bit is high.
- `err_timeout` out 1: sticky; set on timeout.
- `err_unmapped` out 1: sticky; set on an access with no select.
- `err_addr` out 16: address of the first error since the last clear.
- `err_clr` in 1: synchronous clear of all err outputs.

## Operation
- Two-state FSM: IDLE and WAIT.

Access start:
- An access starts in IDLE when `cpu_mc`==3'b111 and `cpu_io_op`!=00. This is the "access cycle".
- Winner is the lowest-index asserted `slv_sel` bit.
- In the access cycle, the winner's `slv_we` or `slv_re` is high. Strobes are combinational, exactly one cycle, and never asserted in WAIT.

Completion:
- `done` = winner's `slv_ready`. In WAIT, `done` uses the winner index latched at the access cycle.
- Done in the access cycle: stay in IDLE, `cpu_wait`=0, zero wait states.
- Not done: `cpu_wait`=1 combinationally in the access cycle, then go to WAIT. `cpu_wait` stays 1 until and excluding the first done cycle.
- Read completion: on the clock edge ending the done cycle, `cpu_data_in` <= winner's rdata. Otherwise `cpu_data_in` holds its value.
- Write completion: `cpu_data_in` is unchanged.

Unmapped access (no `slv_sel` bit):
- Completes in the access cycle with no strobe.
- Reads load DEFAULT_RDATA.
- `err_unmapped` is set, and `err_addr` is loaded if no error is already latched.

Other rules:
- `cpu_mc`==7 with an op while in WAIT is ignored; no new access starts.
- `err_clr` takes priority over error sets in the same cycle.
- Reset, asynchronous and possible mid-access, forces the following immediately; a pending slave access is abandoned:
  - FSM to IDLE.
  - `cpu_wait`=0, all strobes 0.
  - `cpu_data_in`=RESET_RDATA.
  - err flags 0, `err_addr`=0.
  - Timeout counter 0.

## Timing
- Zero-wait read latency: data is captured at the end of MC=7 and is visible to the core from MC=5 onward. Slaves with 1-cycle synchronous read (RAM/ROM) tie ready high.
- Each cycle in WAIT adds one clk of stretch.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Cleared in the access cycle and incremented each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without done, that cycle is treated as done:
    - reads load DEFAULT_RDATA;
    - `err_timeout` is set and `err_addr` latched (first error only);
    - the FSM returns to IDLE.
- If ready and the timeout coincide in the same cycle, ready wins: real data is loaded and no error is raised.

## Configuration
- `BUS_TIMEOUT_EN` defined: timeout counter and `err_timeout` are present, as above.
- `BUS_TIMEOUT_EN` undefined:
  - WAIT persists until ready, indefinitely.
  - No counter is built; `err_timeout` is tied 0.
  - `err_addr` captures unmapped accesses only.

## Structure
- Shared package `bus_pkg`:
  - IO_Op encodings (`IO_NONE`, `IO_WRITE`, `IO_READ`, `IO_FETCH`);
  - MC constant `MC_ACCESS`=3'b111;
  - FSM state typedef.
- Sub-module `bus_prio_sel`: parametrised lowest-index priority encoder. Outputs winner index, valid flag and the muxed 8-bit rdata.

## Test plan
- Read from slave 0, ready tied 1, rdata 8'h5A, access at MC=7: one `slv_re[0]` pulse, `cpu_wait` never 1, `cpu_data_in`=8'h5A after that edge.
- Write 8'h3C to slave 2, ready asserted 3 cycles late: `slv_we[2]` for one cycle with `slv_wdata`=8'h3C, `cpu_wait` high exactly 3 cycles, no second strobe.
- `slv_sel`=4'b0110 with rdata1=8'h11 and rdata2=8'h22: slave 1 wins and `cpu_data_in`=8'h11.
- Read at 16'hD000 with no select: no strobes, `cpu_data_in`=8'hFF, `err_unmapped`=1, `err_addr`=16'hD000; `err_clr` clears all three err outputs.
- With `BUS_TIMEOUT_EN` and TIMEOUT_CYCLES=4, slave ready stuck at 0: `cpu_wait` releases after 4 WAIT cycles, data 8'hFF, `err_timeout`=1. Repeat with ready rising on the 4th WAIT cycle: real data loaded and no error.
- Assert `rst_n` low during WAIT: `cpu_wait`, strobes and err outputs drop to 0 immediately and `cpu_data_in`=8'hEA; the first access after reset completes normally.
